// File: rtl/mccu_fsm_if.sv
// Control bundle between the multi-cycle control unit and the datapath.
// master = control unit (drives enables/selects), slave = datapath.
interface mccu_fsm_if #(
   parameter int unsigned INSTRET_W = 32
);
   logic [5:0]           op;
   logic [5:0]           func;
   logic                 z;
   logic                 mem_rdy;
   logic                 mem_req;
   logic                 iord;
   logic                 wpc;
   logic                 wir;
   logic                 wmem;
   logic                 wreg;
   logic                 regrt;
   logic                 m2reg;
   logic                 jal;
   logic                 shift;
   logic                 sext;
   logic                 alusrca;
   logic [1:0]           alusrcb;
   logic [3:0]           aluc;
   logic [1:0]           pcsource;
   logic                 illegal;
   logic [2:0]           state;
   logic [INSTRET_W-1:0] instret;

   modport master (
      input  op, func, z, mem_rdy,
      output mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, jal, shift, sext,
             alusrca, alusrcb, aluc, pcsource, illegal, state, instret
   );

   modport slave (
      output op, func, z, mem_rdy,
      input  mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, jal, shift, sext,
             alusrca, alusrcb, aluc, pcsource, illegal, state, instret
   );
endinterface

// File: rtl/mccu_fsm.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencing with memory
// wait states, illegal-op flag and a retired-instruction counter.
module mccu_fsm #(
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter int unsigned INSTRET_W     = 32
) (
   input logic         clk,
   input logic         rst,
   mccu_fsm_if.master  bus
);

   typedef enum logic [2:0] {
      StIf  = 3'd0,
      StId  = 3'd1,
      StExe = 3'd2,
      StMem = 3'd3,
      StWb  = 3'd4
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   state_e               state_q, state_d;
   logic [INSTRET_W-1:0] instret_q;
   logic                 retire;
   logic                 done;

   // Instruction decode
   logic r_type;
   logic i_add, i_sub, i_and, i_or, i_xor, i_nor, i_slt, i_sll, i_srl, i_sra, i_jr, i_jalr;
   logic i_addi, i_andi, i_ori, i_xori, i_slti, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
   logic i_type, legal, is_shift, is_sext;
   logic [3:0] alu_op;

   assign r_type = (bus.op == OP_R);
   assign i_add  = r_type & (bus.func == F_ADD);
   assign i_sub  = r_type & (bus.func == F_SUB);
   assign i_and  = r_type & (bus.func == F_AND);
   assign i_or   = r_type & (bus.func == F_OR);
   assign i_xor  = r_type & (bus.func == F_XOR);
   assign i_nor  = r_type & (bus.func == F_NOR);
   assign i_slt  = r_type & (bus.func == F_SLT);
   assign i_sll  = r_type & (bus.func == F_SLL);
   assign i_srl  = r_type & (bus.func == F_SRL);
   assign i_sra  = r_type & (bus.func == F_SRA);
   assign i_jr   = r_type & (bus.func == F_JR);
   assign i_jalr = r_type & (bus.func == F_JALR);
   assign i_addi = (bus.op == OP_ADDI);
   assign i_andi = (bus.op == OP_ANDI);
   assign i_ori  = (bus.op == OP_ORI);
   assign i_xori = (bus.op == OP_XORI);
   assign i_slti = (bus.op == OP_SLTI);
   assign i_lui  = (bus.op == OP_LUI);
   assign i_lw   = (bus.op == OP_LW);
   assign i_sw   = (bus.op == OP_SW);
   assign i_beq  = (bus.op == OP_BEQ);
   assign i_bne  = (bus.op == OP_BNE);
   assign i_j    = (bus.op == OP_J);
   assign i_jal  = (bus.op == OP_JAL);

   // I-type here means "ALU B operand is the extended immediate"
   assign i_type   = i_addi | i_andi | i_ori | i_xori | i_slti | i_lui | i_lw | i_sw;
   assign is_shift = i_sll | i_srl | i_sra;
   assign is_sext  = i_addi | i_slti | i_lw | i_sw | i_beq | i_bne;
   assign legal    = i_add | i_sub | i_and | i_or | i_xor | i_nor | i_slt | i_sll | i_srl
                   | i_sra | i_jr | i_jalr | i_type | i_beq | i_bne | i_j | i_jal;

   always_comb begin
      alu_op = 4'b0000;
      if (i_sub)                                    alu_op = 4'b0100;
      else if (i_and | i_andi)                      alu_op = 4'b0001;
      else if (i_or | i_ori)                        alu_op = 4'b0101;
      else if (i_xor | i_xori | i_beq | i_bne)      alu_op = 4'b0010;
      else if (i_nor)                               alu_op = 4'b1101;
      else if (i_slt | i_slti)                      alu_op = 4'b1000;
      else if (i_sll)                               alu_op = 4'b0011;
      else if (i_srl)                               alu_op = 4'b0111;
      else if (i_sra)                               alu_op = 4'b1111;
      else if (i_lui)                               alu_op = 4'b0110;
   end

   assign done = MEM_HANDSHAKE ? bus.mem_rdy : 1'b1;

   // State and retired-instruction counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIf;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + INSTRET_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         StIf: begin
            if (done) state_d = StId;
         end
         StId: begin
            if (!legal) begin
               state_d = StIf;
            end else if (i_j | i_jal | i_jr | i_jalr) begin
               state_d = StIf;
               retire  = 1'b1;
            end else begin
               state_d = StExe;
            end
         end
         StExe: begin
            if (i_beq | i_bne) begin
               state_d = StIf;
               retire  = 1'b1;
            end else if (i_lw | i_sw) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            if (done) begin
               if (i_sw) begin
                  state_d = StIf;
                  retire  = 1'b1;
               end else begin
                  state_d = StWb;
               end
            end
         end
         StWb: begin
            state_d = StIf;
            retire  = 1'b1;
         end
         default: state_d = StIf;
      endcase
   end

   // Outputs; everything held at zero while rst is high
   always_comb begin
      bus.mem_req  = 1'b0;
      bus.iord     = 1'b0;
      bus.wpc      = 1'b0;
      bus.wir      = 1'b0;
      bus.wmem     = 1'b0;
      bus.wreg     = 1'b0;
      bus.regrt    = 1'b0;
      bus.m2reg    = 1'b0;
      bus.jal      = 1'b0;
      bus.shift    = 1'b0;
      bus.sext     = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.aluc     = 4'b0000;
      bus.pcsource = 2'b00;
      bus.illegal  = 1'b0;
      if (!rst) begin
         bus.regrt = i_type;
         bus.shift = is_shift;
         bus.m2reg = i_lw;
         bus.sext  = is_sext;
         unique case (state_q)
            StIf: begin
               bus.mem_req = 1'b1;
               bus.alusrcb = 2'b01;
               bus.wir     = done;
               bus.wpc     = done;
            end
            StId: begin
               bus.alusrcb = 2'b11;
               if (!legal) begin
                  bus.illegal = 1'b1;
               end else if (i_j | i_jal) begin
                  bus.wpc      = 1'b1;
                  bus.pcsource = 2'b11;
                  bus.wreg     = i_jal;
                  bus.jal      = i_jal;
               end else if (i_jr | i_jalr) begin
                  bus.wpc      = 1'b1;
                  bus.pcsource = 2'b10;
                  bus.wreg     = i_jalr;
                  bus.jal      = i_jalr;
               end
            end
            StExe: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = i_type ? 2'b10 : 2'b00;
               bus.aluc    = alu_op;
               if (i_beq | i_bne) begin
                  bus.pcsource = 2'b01;
                  bus.wpc      = (i_beq & bus.z) | (i_bne & ~bus.z);
               end
            end
            StMem: begin
               bus.mem_req = 1'b1;
               bus.iord    = 1'b1;
               bus.wmem    = i_sw;
            end
            StWb: begin
               bus.wreg = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.state   = rst ? 3'd0 : state_q;
   assign bus.instret = rst ? '0 : instret_q;

endmodule

// File: doc/mccu_fsm.md
Name: mccu_fsm

Overview:
- Multi-cycle control unit for the MIPS-subset datapath; successor to the single-cycle control decoder.
- Sequences each instruction through IF/ID/EXE/MEM/WB with a shared ALU and a unified memory behind a ready handshake.
- Adds mem wait states, an illegal-op flag and a retired-instruction counter.
- Sits between the IR and the multi-cycle datapath's muxes and write enables.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_rdy; 0: memory states take exactly one cycle and mem_rdy is ignored.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- op  input  6  IR[31:26], held stable by the datapath while wir=0
- func  input  6  IR[5:0]
- z  input  1  ALU zero flag, valid in EXE
- mem_rdy  input  1  memory access complete this cycle
- mem_req  output  1  memory access request
- iord  output  1  address select: 0 = PC, 1 = ALU result
- wpc  output  1  PC write enable
- wir  output  1  IR write enable
- wmem  output  1  memory write enable
- wreg  output  1  register-file write enable
- regrt  output  1  destination rt (1) or rd (0)
- m2reg  output  1  write-back data from memory
- jal  output  1  destination $31, data PC
- shift  output  1  ALU A = sa
- sext  output  1  sign-extend imm16 (0 = zero-extend)
- alusrca  output  1  0 = PC, 1 = reg A / sa
- alusrcb  output  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = sext imm<<2
- aluc  output  4  ALU op
- pcsource  output  2  00 = ALU, 01 = branch target reg, 10 = reg A (jr), 11 = jump address
- illegal  output  1  unsupported op/func decoded in ID
- state  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
- instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Registers: state and instret only. All other outputs are combinational from state, op, func, z and mem_rdy.
- Reset: on a clk edge with rst=1, state<=IF and instret<=0, including mid-instruction.
- While rst=1, mem_req, wpc, wir, wmem, wreg and illegal are forced to 0. All other outputs are 0 during reset.
- Supported instructions: add, sub, and, or, xor, nor, slt, sll, srl, sra, jr, jalr, addi, andi, ori, xori, slti, lui, lw, sw, beq, bne, j, jal. The opcode/func encodings are the standard MIPS ones used by the current decoder.
- aluc encoding:
  - add/addi/lw/sw/address: 0000
  - sub: 0100
  - and/andi: 0001
  - or/ori: 0101
  - xor/xori/beq/bne: 0010
  - nor: 1101
  - slt/slti: 1000
  - sll: 0011
  - srl: 0111
  - sra: 1111
  - lui: 0110
- sext=1 for addi, slti, lw, sw, beq, bne. regrt, shift and m2reg follow the single-cycle rules in every state.
- Let done = mem_rdy when MEM_HANDSHAKE=1, else 1.
- IF:
  - Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=0000, pcsource=00.
  - When done: wir=1 and wpc=1 (PC+4); next state ID. Otherwise stay in IF with wir=0 and wpc=0.
- ID:
  - Outputs: alusrca=0, alusrcb=11, aluc=0000 (branch target latched by datapath).
  - j: wpc=1, pcsource=11 -> IF.
  - jal: additionally wreg=1, jal=1 -> IF.
  - jr: wpc=1, pcsource=10 -> IF.
  - jalr: additionally wreg=1, jal=1 -> IF.
  - Illegal op/func: illegal=1 for this one cycle, no writes -> IF. Not counted as retired.
  - Otherwise -> EXE.
- EXE:
  - Outputs: alusrca=1; alusrcb=10 for I-type, 00 otherwise; aluc as above.
  - beq/bne: wpc=(beq&z)|(bne&~z), pcsource=01 -> IF.
  - lw/sw -> MEM. All others -> WB.
- MEM:
  - Outputs: mem_req=1, iord=1; wmem=1 for sw (held until done).
  - Stay while !done. On done: sw -> IF, lw -> WB.
- WB: wreg=1, m2reg=lw, regrt=I-type -> IF.
- Retire: instret increments by 1 on every transition into IF from ID, EXE, MEM or WB, excluding the illegal case. It wraps from 2^INSTRET_W-1 to 0.
- Simultaneous rst and retire: reset wins and instret becomes 0.
- mem_rdy outside IF/MEM is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MEM of an sw -> state=0, instret=0, and wmem=0 and mem_req=0 while rst=1.
- add, MEM_HANDSHAKE=1, mem_rdy=1 always -> states 0,1,2,4,0; in WB wreg=1, regrt=0, aluc=0000; instret=1 after 4 cycles.
- lw with mem_rdy low for 3 cycles in MEM -> MEM lasts 4 cycles with mem_req=1 and iord=1; WB has m2reg=1 and regrt=1; total 8 cycles.
- beq, z=1 then bne, z=1 -> beq: EXE wpc=1, pcsource=01; bne: wpc=0; both return to IF after 3 cycles.
- jal -> ID has wpc=1, pcsource=11, wreg=1, jal=1, then IF; op=6'h3f -> illegal=1 for one cycle and instret unchanged.
- INSTRET_W=4: 17 retired instructions -> instret=1 (wrapped); MEM_HANDSHAKE=0 with mem_rdy=0 -> lw still completes in 5 cycles.
